// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - request/result bundle between the execute stage and the multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_lo, product_hi
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_lo, product_hi
    );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add unsigned multiplier, WIDTH-cycle latency
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    seq_multiplier_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_prod_lo;
    logic [WIDTH-1:0] r_prod_hi;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic             w_last;
    logic             w_accept;

    // Carry out of the add becomes hi's MSB after the shift, so nothing is lost.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_hi_nx  = w_sum[WIDTH:1];
        w_lo_nx  = {w_sum[0], r_lo[WIDTH-1:1]};
        w_last   = (r_cnt == CNT_W'(WIDTH - 1));
        w_accept = (r_state == S_IDLE) && bus.start;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_prod_lo <= '0;
            r_prod_hi <= '0;
        end else if (w_accept) begin
            r_a   <= bus.multiplicand;
            r_hi  <= '0;
            r_lo  <= bus.multiplier;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_prod_hi <= w_hi_nx;
                r_prod_lo <= w_lo_nx;
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.product_lo = r_prod_lo;
    assign bus.product_hi = r_prod_hi;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier with reference products
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [127:0] exp_q[$];

    seq_multiplier_if #(.WIDTH(64)) bus ();

    seq_multiplier #(.WIDTH(64)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa;
        logic [127:0] wb;
        wa = {64'd0, a};
        wb = {64'd0, b};
        return wa * wb;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got product %0h expected no done",
                         {bus.product_hi, bus.product_lo});
            end else begin
                chk("product", {bus.product_hi, bus.product_lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) bcnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int bcnt;
        int busy_low;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_prod", {bus.product_hi, bus.product_lo}, 0);
        repeat (10) @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_prod", {bus.product_hi, bus.product_lo}, 0);

        // 57 * 8: latency, busy length, hold
        issue(64'd57, 64'd8);
        wait_done(lat, bcnt);
        chk("lat_57x8", lat, 64);
        chk("busy_len_57x8", bcnt, 65);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_lo", bus.product_lo, 456);
            chk("hold_hi", bus.product_hi, 0);
        end
        chk("idle_after_busy", bus.busy, 0);

        // All-ones operands, then a zero operand
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(lat, bcnt);
        chk("lat_ones", lat, 64);
        chk("ones_hi", bus.product_hi, 128'hFFFF_FFFF_FFFF_FFFE);
        chk("ones_lo", bus.product_lo, 1);
        issue(64'd0, 64'd12345);
        wait_done(lat, bcnt);
        chk("zero_prod", {bus.product_hi, bus.product_lo}, 0);

        // Start during RUN is ignored; products do not move mid-operation
        issue(64'd3, 64'd5);
        repeat (10) @(negedge clk);
        bus.multiplicand = 64'd7;
        bus.multiplier   = 64'd7;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_mid_run", bus.busy, 1);
        chk("prod_stable_run", {bus.product_hi, bus.product_lo}, 0);
        wait_done(lat, bcnt);
        chk("lat_poke", lat, 53);
        chk("busy_poke", bcnt, 54);
        chk("poke_lo", bus.product_lo, 15);
        repeat (80) @(negedge clk);
        chk("poke_idle", bus.busy, 0);

        // Reset mid-operation aborts without a done pulse
        issue(64'd57, 64'd8);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("abort_busy", bus.busy, 0);
        chk("abort_prod", {bus.product_hi, bus.product_lo}, 0);
        busy_low = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) busy_low++;
        end
        chk("abort_stays_idle", busy_low, 0);
        issue(64'd6, 64'd7);
        wait_done(lat, bcnt);
        chk("lat_after_abort", lat, 64);
        chk("after_abort_lo", bus.product_lo, 42);

        // Back-to-back: start while done is high is dropped, next cycle accepted
        issue(64'h1_0000_0001, 64'h1_0000_0000);
        wait_done(lat, bcnt);
        chk("b2b_hi", bus.product_hi, 1);
        chk("b2b_lo", bus.product_lo, 128'h1_0000_0000);
        bus.multiplicand = 64'd5;
        bus.multiplier   = 64'd5;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.multiplicand = 64'd9;
        bus.multiplier   = 64'd9;
        exp_q.push_back(ref_mul(64'd9, 64'd9));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1);
        wait_done(lat, bcnt);
        chk("lat_b2b", lat, 64);
        chk("b2b_81", bus.product_lo, 81);

        // Randomised operands against the reference product
        for (int i = 0; i < 10; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 3 == 1) a = a >> $urandom_range(63, 0);
            if (i % 4 == 2) b = b >> $urandom_range(63, 0);
            issue(a, b);
            wait_done(lat, bcnt);
            chk("lat_rand", lat, 64);
            chk("busy_rand", bcnt, 65);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle unsigned shift-add multiplier for the datapath's execute stage, the inverse operation to the division program the single-cycle core runs in software. `iExecute` issues a one-cycle `start` with two operands. The block returns the full double-width product (low half for `MUL`, high half for `UMULH`) after a fixed latency, framed by `busy`/`done`. It owns no architectural state; results are captured by the surrounding stage when `done` is high.

## Interface
- `WIDTH`, default 64 (`WORD`): operand width; product is 2*`WIDTH`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `multiplicand`  in  `WIDTH`  operand A, unsigned; latched on accepted `start`.
- `multiplier`  in  `WIDTH`  operand B, unsigned; latched on accepted `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; product valid.
- `product_lo`  out  `WIDTH`  bits [`WIDTH`-1:0] of A*B.
- `product_hi`  out  `WIDTH`  bits [2*`WIDTH`-1:`WIDTH`] of A*B.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - `start`=1 → latch A into the multiplicand register.
  - Load the accumulator {hi, lo} = {0, B}.
  - Clear the step counter and go to RUN.
  - `start`=0 → stay in IDLE.
- RUN, one radix-2 step per cycle:
  - sum = hi + (lo[0] ? A : 0), computed at `WIDTH`+1 bits (carry kept).
  - {carry, hi, lo} ← {carry, sum, lo} >> 1. The carry enters hi's MSB.
  - counter ← counter + 1.
  - After the step with counter = `WIDTH`-1: copy hi→`product_hi` and lo→`product_lo`, then go to DONE.
- DONE: `done`=1 for exactly this one cycle, then go to IDLE unconditionally.
- `start` in RUN or DONE: ignored, not queued. Operands change mid-op with no effect (already latched).
- `product_lo`/`product_hi` hold their value from the last completed operation until the next completion or reset. They do not change during RUN.
- Counter width is clog2(`WIDTH`). It never wraps within an operation.
- Arithmetic is unsigned only. There are no overflow or status flags; the 2*`WIDTH` product is exact.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `product_lo`=0, `product_hi`=0, counter=0, internal registers=0.
- `reset` takes priority over every other condition. Asserted in RUN or DONE, it aborts the operation: no `done` pulse, products stay 0, IDLE on the next edge.
- `start` accepted at edge k:
  - `busy`=1 from edge k.
  - RUN steps occur on edges k+1 … k+`WIDTH`; DONE is entered at edge k+`WIDTH`.
  - `done`=1 and products valid during the cycle after edge k+`WIDTH`.
  - `busy`=`done`=0 from edge k+`WIDTH`+1.
  - Latency from accept to `done` is `WIDTH` cycles (64 at default).
- Earliest next accept is edge k+`WIDTH`+1, where `start` is sampled in IDLE. Sustained throughput is one operation per `WIDTH`+1 cycles.
- `start` and `reset` high on the same edge: reset wins and nothing is accepted.
- All outputs come from registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset (hold `reset`=1 for 2 cycles, then release) → all outputs 0. 10 idle cycles with `start`=0 → still 0.
- A=57, B=8, pulse `start` → `busy` for 65 cycles. `done`=1 exactly 64 cycles after accept, with `product_lo`=456 and `product_hi`=0. Products hold 456/0 for 20 further cycles.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF → `product_hi`=0xFFFF_FFFF_FFFF_FFFE, `product_lo`=1. Then A=0, B=12345 → both 0 (zero operand, no stale carry).
- A=3, B=5 accepted, then `start` with A=7, B=7 at cycle 10 of RUN → the second request is ignored. Single `done` with `product_lo`=15. `busy` stays 1 throughout.
- A=57, B=8, `reset` asserted at cycle 30 of RUN → no `done` pulse, products 0, IDLE next edge. A fresh `start` with A=6, B=7 then yields `product_lo`=42 after 64 cycles.
- Back-to-back: A=2³²+1, B=2³² → `product_hi`=1, `product_lo`=2³². Re-issue `start` on the cycle `done` is high → ignored. Issue it one cycle later with A=9, B=9 → accepted, `product_lo`=81 after 64 cycles.
